// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper: host-facing UART command port.
//   Receives 8N1 bytes on RX and pairs them (high byte first) into a 16-bit command.
//   Serializes 8-bit response bytes back out on TX.
// Ports:
//   clk, rst_n           system clock, async active-low reset
//   RX / TX              serial in (idles high) / serial out (idles high)
//   cmd, cmd_rdy         assembled command and its level-valid flag
//   clr_cmd_rdy          consumer acknowledge, clears cmd_rdy next cycle
//   resp, send_resp      byte to send and its one-cycle load strobe
//   resp_sent            one-cycle pulse when the stop bit has completed
// Build option: define CMD_TIMEOUT_EN to drop a lone high byte after TIMEOUT_CLKS idle clocks.
module uart_cmd_wrapper #(
  parameter int unsigned BAUD_DIV     = 108,
  parameter int unsigned TIMEOUT_CLKS = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned BIT_W = 4;
  localparam logic [CNT_W-1:0] BAUD_FULL  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] BAUD_HALF  = CNT_W'(BAUD_DIV / 2 - 1);
  // The LOAD cycle already drives the start bit, so SHIFT owes one cycle less for it.
  localparam logic [CNT_W-1:0] BAUD_FIRST = CNT_W'(BAUD_DIV - 2);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SHIFT} tx_state_t;

  // ---------------- RX path ----------------
  rx_state_t        rx_state, rx_nxt;
  logic             rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0] rx_baud;
  logic [BIT_W-1:0] rx_bit_cnt;
  logic [7:0]       rx_shift;
  logic             rx_tick, rx_start_c, rx_byte_ok_c, rx_frame_err_c;

  assign rx_tick = (rx_baud == '0);

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_nxt;
  end

  always_comb begin
    rx_nxt = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync)                 rx_nxt = RX_START;
      RX_START: if (rx_tick)                             rx_nxt = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit_cnt == BIT_W'(7))  rx_nxt = RX_STOP;
      RX_STOP:  if (rx_tick)                             rx_nxt = RX_IDLE;
      default:                                           rx_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_start_c     = 1'b0;
    rx_byte_ok_c   = 1'b0;
    rx_frame_err_c = 1'b0;
    if (rx_state == RX_IDLE) rx_start_c = rx_prev && !rx_sync;
    if (rx_state == RX_STOP && rx_tick) begin
      rx_byte_ok_c   = rx_sync;
      rx_frame_err_c = !rx_sync;
    end
  end

  // Idle keeps the half-bit preload ready; every sample point reloads a full bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_baud    <= '0;
      rx_bit_cnt <= '0;
      rx_shift   <= '0;
    end else if (rx_state == RX_IDLE) begin
      rx_baud    <= BAUD_HALF;
      rx_bit_cnt <= '0;
    end else if (rx_tick) begin
      rx_baud <= BAUD_FULL;
      if (rx_state == RX_DATA) begin
        rx_shift   <= {rx_sync, rx_shift[7:1]};
        rx_bit_cnt <= rx_bit_cnt + BIT_W'(1);
      end
    end else begin
      rx_baud <= rx_baud - CNT_W'(1);
    end
  end

  // ---------------- Command assembly ----------------
  logic       ptr_low;
  logic [7:0] hi_byte;
  logic       timeout_hit;

`ifdef CMD_TIMEOUT_EN
  logic [CNT_W-1:0] to_cnt;

  // Counts idle clocks while a high byte waits for its partner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      to_cnt <= '0;
    else if (!ptr_low || rx_start_c) to_cnt <= '0;
    else if (!timeout_hit)           to_cnt <= to_cnt + CNT_W'(1);
  end

  assign timeout_hit = ptr_low && (to_cnt == CNT_W'(TIMEOUT_CLKS));
`else
  // TIMEOUT_CLKS is referenced so the parameter list stays identical in both builds.
  assign timeout_hit = 1'b0 & (TIMEOUT_CLKS == 0);
`endif

  // A completing low byte takes priority over an acknowledge in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_low <= 1'b0;
      hi_byte <= '0;
      cmd     <= '0;
      cmd_rdy <= 1'b0;
    end else if (rx_byte_ok_c) begin
      if (ptr_low) begin
        cmd     <= {hi_byte, rx_shift};
        cmd_rdy <= 1'b1;
        ptr_low <= 1'b0;
      end else begin
        hi_byte <= rx_shift;
        cmd_rdy <= 1'b0;
        ptr_low <= 1'b1;
      end
    end else begin
      if (rx_frame_err_c || timeout_hit) ptr_low <= 1'b0;
      if (clr_cmd_rdy)                   cmd_rdy <= 1'b0;
    end
  end

  // ---------------- TX path ----------------
  tx_state_t        tx_state, tx_nxt;
  logic [CNT_W-1:0] tx_baud;
  logic [BIT_W-1:0] tx_bit_cnt;
  logic [8:0]       tx_shift;
  logic             tx_tick, tx_go_c, tx_adv_c, tx_done_c;

  assign tx_tick = (tx_baud == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_nxt;
  end

  always_comb begin
    tx_nxt = tx_state;
    unique case (tx_state)
      TX_IDLE:  if (send_resp && !resp_sent)             tx_nxt = TX_LOAD;
      TX_LOAD:                                           tx_nxt = TX_SHIFT;
      TX_SHIFT: if (tx_tick && tx_bit_cnt == BIT_W'(9))  tx_nxt = TX_IDLE;
      default:                                           tx_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_go_c   = 1'b0;
    tx_adv_c  = 1'b0;
    tx_done_c = 1'b0;
    unique case (tx_state)
      TX_IDLE:  tx_go_c = send_resp && !resp_sent;
      TX_SHIFT: begin
        tx_adv_c  = tx_tick && (tx_bit_cnt != BIT_W'(9));
        tx_done_c = tx_tick && (tx_bit_cnt == BIT_W'(9));
      end
      default: ;
    endcase
  end

  // tx_shift holds {stop, data}; the start bit is driven directly on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      TX         <= 1'b1;
      tx_shift   <= '1;
      tx_baud    <= '0;
      tx_bit_cnt <= '0;
      resp_sent  <= 1'b0;
    end else begin
      resp_sent <= tx_done_c;
      if (tx_go_c) begin
        tx_shift <= {1'b1, resp};
        TX       <= 1'b0;
      end else if (tx_adv_c) begin
        tx_shift <= {1'b1, tx_shift[8:1]};
        TX       <= tx_shift[0];
      end else if (tx_done_c) begin
        TX <= 1'b1;
      end
      if (tx_state == TX_LOAD) begin
        tx_baud    <= BAUD_FIRST;
        tx_bit_cnt <= '0;
      end else if (tx_state == TX_SHIFT) begin
        if (tx_tick) begin
          tx_baud    <= BAUD_FULL;
          tx_bit_cnt <= tx_bit_cnt + BIT_W'(1);
        end else begin
          tx_baud <= tx_baud - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Self-checking bench for uart_cmd_wrapper: RX command pairing, framing errors,
// pending-command stability, TX framing/timing, strobe rejection, timeout, reset.
module tb_uart_cmd_wrapper;

  localparam int BAUD    = 108;
  localparam int TO_CLKS = 2000;
  // Last negedge before the DUT samples the stop bit (2-flop sync + edge + half bit).
  localparam int STOP_SAMPLE = 9 * BAUD + BAUD / 2 + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;

  int checks = 0;
  int errors = 0;

  // Reference model of the command assembler.
  bit          m_ptr_low;
  logic [7:0]  m_hi;
  logic [15:0] m_cmd;
  bit          m_rdy;

  int   rdy_rises = 0;
  logic rdy_q = 1'b0;

  always #5 clk = ~clk;

  uart_cmd_wrapper #(.BAUD_DIV(BAUD), .TIMEOUT_CLKS(TO_CLKS)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent)
  );

  always @(negedge clk) begin
    if (cmd_rdy === 1'b1 && rdy_q !== 1'b1) rdy_rises++;
    rdy_q = cmd_rdy;
  end

  task automatic model_reset();
    m_ptr_low = 0; m_hi = 8'h00; m_cmd = 16'h0000; m_rdy = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) m_ptr_low = 0;
    else if (m_ptr_low) begin m_cmd = {m_hi, b}; m_rdy = 1; m_ptr_low = 0; end
    else begin m_hi = b; m_rdy = 0; m_ptr_low = 1; end
  endtask

  task automatic model_idle(input int cycles);
`ifdef CMD_TIMEOUT_EN
    if (m_ptr_low && cycles > TO_CLKS) m_ptr_low = 0;
`endif
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return d[idx-1];
  endfunction

  // Sends one 8N1 byte; checks cmd/cmd_rdy just before and just after the stop sample.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit clr_coinc);
    @(negedge clk);
    for (int c = 0; c < 10 * BAUD; c++) begin
      int bi;
      bi = c / BAUD;
      if (bi == 0)      RX = 1'b0;
      else if (bi == 9) RX = stop_ok;
      else              RX = b[bi-1];
      if (c == STOP_SAMPLE) begin
        checks++;
        if (cmd_rdy !== m_rdy || cmd !== m_cmd) begin
          errors++;
          $display("FAIL pre_stop byte=%02h: cmd=%04h rdy=%b, expected cmd=%04h rdy=%b", b, cmd, cmd_rdy, m_cmd, m_rdy);
        end
        if (clr_coinc) begin clr_cmd_rdy = 1'b1; m_rdy = 0; end
        model_byte(b, stop_ok);
      end
      if (c == STOP_SAMPLE + 1) begin
        clr_cmd_rdy = 1'b0;
        checks++;
        if (cmd_rdy !== m_rdy || cmd !== m_cmd) begin
          errors++;
          $display("FAIL post_stop byte=%02h: cmd=%04h rdy=%b, expected cmd=%04h rdy=%b", b, cmd, cmd_rdy, m_cmd, m_rdy);
        end
      end
      @(negedge clk);
    end
    RX = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_clr();
    @(negedge clk); clr_cmd_rdy = 1'b1;
    @(negedge clk); clr_cmd_rdy = 1'b0; m_rdy = 0;
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL clr_cmd_rdy: rdy=%b, expected 0", cmd_rdy);
    end
  endtask

  task automatic check_cmd(input string name);
    checks++;
    if (cmd !== m_cmd || cmd_rdy !== m_rdy) begin
      errors++;
      $display("FAIL %s: cmd=%04h rdy=%b, expected cmd=%04h rdy=%b", name, cmd, cmd_rdy, m_cmd, m_rdy);
    end
  endtask

  // Sends one response and checks TX and resp_sent every cycle of the frame.
  task automatic tx_frame(input logic [7:0] r, input int inj, input bit coinc);
    logic exp_tx;
    int   bad_tx = 0;
    int   bad_rs = 0;
    @(negedge clk); resp = r; send_resp = 1'b1;
    @(negedge clk); send_resp = 1'b0;
    for (int k = 1; k <= 10 * BAUD + 1; k++) begin
      exp_tx = frame_bit(r, (k - 1) / BAUD);
      checks += 2;
      if (TX !== exp_tx) begin
        errors++; bad_tx++;
        if (bad_tx <= 4) $display("FAIL tx_bit resp=%02h cycle=%0d: TX=%b, expected %b", r, k, TX, exp_tx);
      end
      if (resp_sent !== (k == 10 * BAUD + 1)) begin
        errors++; bad_rs++;
        if (bad_rs <= 4) $display("FAIL resp_sent resp=%02h cycle=%0d: got %b, expected %b", r, k, resp_sent, k == 10 * BAUD + 1);
      end
      send_resp = (k == inj) || (coinc && k == 10 * BAUD + 1);
      if (k == inj) resp = 8'hFF;
      @(negedge clk);
    end
    send_resp = 1'b0;
    for (int k = 0; k < 150; k++) begin
      checks++;
      if (TX !== 1'b1 || resp_sent !== 1'b0) begin
        errors++; bad_tx++;
        if (bad_tx <= 4) $display("FAIL tx_after_frame cycle=%0d: TX=%b resp_sent=%b, expected 1/0", k, TX, resp_sent);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (TX !== 1'b1 || cmd !== 16'h0000 || cmd_rdy !== 1'b0 || resp_sent !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: TX=%b cmd=%04h rdy=%b resp_sent=%b, expected 1 0000 0 0", TX, cmd, cmd_rdy, resp_sent);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_cmd("after_reset");
  endtask

  task automatic test_cmd_basic();
    send_byte(8'h41, 1'b1, 1'b0);
    send_byte(8'h10, 1'b1, 1'b0);
    check_cmd("cmd_4110");
    do_clr();
  endtask

  task automatic test_tx();
    tx_frame(8'hA5, -1, 1'b0);
    tx_frame(8'hA5, int'($urandom_range(2, 1000)), 1'b1);
    tx_frame(8'($urandom), int'($urandom_range(2, 1000)), 1'b0);
  endtask

  task automatic test_framing();
    int r0;
    r0 = rdy_rises;
    send_byte(8'h40, 1'b0, 1'b0);
    send_byte(8'h40, 1'b1, 1'b0);
    send_byte(8'h13, 1'b1, 1'b0);
    check_cmd("cmd_4013");
    checks++;
    if (rdy_rises - r0 !== 1) begin
      errors++;
      $display("FAIL rdy_rise_count: got %0d, expected 1", rdy_rises - r0);
    end
    // Framing error on the low byte must also restart pairing.
    send_byte(8'h22, 1'b1, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    send_byte(8'h44, 1'b1, 1'b0);
    send_byte(8'h55, 1'b1, 1'b0);
    check_cmd("cmd_4455");
  endtask

  task automatic test_pending();
    send_byte(8'h41, 1'b1, 1'b0);
    send_byte(8'h10, 1'b1, 1'b0);
    send_byte(8'h81, 1'b1, 1'b0);
    check_cmd("pending_hold_4110");
    send_byte(8'h00, 1'b1, 1'b0);
    check_cmd("cmd_8100");
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      send_byte(8'($urandom), 1'b1, 1'b0);
      send_byte(8'($urandom), 1'b1, (i == 2));
      check_cmd("random_pair");
      if (i == 0) do_clr();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b, r;
    a = 8'($urandom); b = 8'($urandom); r = 8'($urandom);
    fork
      begin send_byte(a, 1'b1, 1'b0); send_byte(b, 1'b1, 1'b0); end
      tx_frame(r, -1, 1'b0);
    join
    check_cmd("concurrent_rx_tx");
  endtask

  task automatic test_timeout();
    send_byte(8'h41, 1'b1, 1'b0);
    repeat (3000) @(negedge clk);
    model_idle(3000);
    send_byte(8'h81, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    check_cmd("timeout_result");
  endtask

  task automatic test_mid_reset();
    if (!m_ptr_low) send_byte(8'h5A, 1'b1, 1'b0);
    @(negedge clk); resp = 8'h3C; send_resp = 1'b1;
    @(negedge clk); send_resp = 1'b0; RX = 1'b0;
    repeat (300) @(negedge clk);
    rst_n = 1'b0; RX = 1'b1;
    @(negedge clk);
    checks++;
    if (TX !== 1'b1 || cmd_rdy !== 1'b0 || cmd !== 16'h0000 || resp_sent !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: TX=%b rdy=%b cmd=%04h resp_sent=%b, expected 1 0 0000 0", TX, cmd_rdy, cmd, resp_sent);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (300) @(negedge clk);
    checks++;
    if (TX !== 1'b1 || resp_sent !== 1'b0) begin
      errors++;
      $display("FAIL tx_idle_after_reset: TX=%b resp_sent=%b, expected 1 0", TX, resp_sent);
    end
    send_byte(8'($urandom), 1'b1, 1'b0);
    send_byte(8'($urandom), 1'b1, 1'b0);
    check_cmd("pair_after_reset");
  endtask

  initial begin
    test_reset();
    test_cmd_basic();
    test_tx();
    test_framing();
    test_pending();
    test_random();
    test_back_to_back();
    test_timeout();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
